// File: rtl/mult_err_pkg.sv
// Shared types and widths for the approximate-multiplier error statistics block.
// Operand width is fixed here at 8 bits to match the 8x8 Booth multipliers under test.
package mult_err_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DW     = 8;
    localparam int PROD_W = 2 * DW;
    localparam int ED_W   = 2 * DW + 1;

    // Unsigned add that clamps at 2^w-1; the accumulator width w may be up to 64 bits.
    function automatic logic [63:0] sat_add_u(input logic [63:0] acc,
                                              input logic [63:0] inc,
                                              input int unsigned w);
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/mult_err_stats_if.sv
// Sample bus carrying operands, the approximate product and the valid/ready handshake.
interface mult_err_stats_if;
    import mult_err_pkg::*;

    logic                     i_valid;
    logic                     o_ready;
    logic signed [DW-1:0]     i_a;
    logic signed [DW-1:0]     i_b;
    logic signed [PROD_W-1:0] i_z_approx;

    modport master (output i_valid, i_a, i_b, i_z_approx, input o_ready);
    modport slave  (input i_valid, i_a, i_b, i_z_approx, output o_ready);

endinterface

// File: rtl/mult_err_pipe.sv
// Two-stage datapath: S1 holds exact and approximate products, S2 holds the error distance.
// With MULT_ERR_BIAS_EN defined, S2 also carries the signed error (approx - exact).
module mult_err_pipe
    import mult_err_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     clear,
    input  logic                     accept,
    input  logic signed [DW-1:0]     a,
    input  logic signed [DW-1:0]     b,
    input  logic signed [PROD_W-1:0] z_approx,
    output logic                     s1_valid,
    output logic                     s2_valid,
`ifdef MULT_ERR_BIAS_EN
    output logic signed [ED_W-1:0]   err,
`endif
    output logic [ED_W-1:0]          ed
);

    logic signed [PROD_W-1:0] exact_q;
    logic signed [PROD_W-1:0] approx_q;
    logic signed [ED_W-1:0]   diff;
    logic [ED_W-1:0]          mag;

    // One extra bit keeps exact - approx from overflowing at the worst-case mismatch.
    assign diff = ED_W'(exact_q) - ED_W'(approx_q);
    assign mag  = diff[ED_W-1] ? ED_W'(-diff) : ED_W'(diff);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
            ed       <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                exact_q  <= PROD_W'(a) * PROD_W'(b);
                approx_q <= z_approx;
            end
            if (s1_valid) begin
                ed <= mag;
            end
        end
    end

`ifdef MULT_ERR_BIAS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= '0;
        end else if (!clear && s1_valid) begin
            err <= -diff;
        end
    end
`endif

endmodule

// File: rtl/mult_err_stats.sv
// Error-metric collector for approximate multipliers: counts erroneous samples, sums and maxes ED.
// Define MULT_ERR_BIAS_EN to add the saturating signed error-bias accumulator o_sum_err.
module mult_err_stats
    import mult_err_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    mult_err_stats_if.slave      bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_sample_cnt,
    output logic [CNT_W-1:0]     o_err_cnt,
    output logic [ACC_W-1:0]     o_sum_ed,
`ifdef MULT_ERR_BIAS_EN
    output logic [ACC_W-1:0]     o_sum_err,
`endif
    output logic [ED_W-1:0]      o_max_ed
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             run_start;
    logic             last_accept;
    logic             s1_valid;
    logic             s2_valid;
    logic [ED_W-1:0]  ed;

    assign bus.o_ready = (state == RUN);
    assign accept      = bus.i_valid && (state == RUN);
    assign run_start   = (state == IDLE) && i_start;
    assign last_accept = accept && (o_sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign o_busy      = (state == RUN) || (state == DRAIN);
    assign o_done      = (state == DONE);

`ifdef MULT_ERR_BIAS_EN
    logic signed [ED_W-1:0] err;
`endif

    mult_err_pipe u_pipe (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clear    (run_start),
        .accept   (accept),
        .a        (bus.i_a),
        .b        (bus.i_b),
        .z_approx (bus.i_z_approx),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
`ifdef MULT_ERR_BIAS_EN
        .err      (err),
`endif
        .ed       (ed)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving DRAIN once S1 is empty lands DONE on the cycle the last ED reaches the stats.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (!s1_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample_cnt <= '0;
            o_err_cnt    <= '0;
            o_sum_ed     <= '0;
            o_max_ed     <= '0;
        end else if (run_start) begin
            o_sample_cnt <= '0;
            o_err_cnt    <= '0;
            o_sum_ed     <= '0;
            o_max_ed     <= '0;
        end else begin
            if (accept) begin
                o_sample_cnt <= o_sample_cnt + CNT_W'(1);
            end
            if (s2_valid) begin
                if (ed != '0) begin
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
                end
                o_sum_ed <= ACC_W'(sat_add_u(64'(o_sum_ed), 64'(ed), ACC_W));
                if (ed > o_max_ed) begin
                    o_max_ed <= ed;
                end
            end
        end
    end

`ifdef MULT_ERR_BIAS_EN
    localparam logic signed [63:0] SMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SMIN = -SMAX - 64'sd1;

    logic signed [63:0] bias_sum;

    assign bias_sum = 64'($signed(o_sum_err)) + 64'(err);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum_err <= '0;
        end else if (run_start) begin
            o_sum_err <= '0;
        end else if (s2_valid) begin
            if (bias_sum > SMAX) begin
                o_sum_err <= ACC_W'(SMAX);
            end else if (bias_sum < SMIN) begin
                o_sum_err <= ACC_W'(SMIN);
            end else begin
                o_sum_err <= ACC_W'(bias_sum);
            end
        end
    end
`endif

endmodule
